pcie_rd_tag_tracker: RTL
========================

Name: pcie_rd_tag_tracker

Overview:
- Sits between the tag allocator and the read-request TLP formatter / completion parser.
- Pairs each DMA read descriptor with an allocated tag and issues the tagged request downstream.
- Records the outstanding DW count per tag and subtracts each completion's payload from it.
- Returns the tag to the allocator's free port once the count reaches zero, so the tag can be reused.

Parameters:
- PCIE_TAG_BITS, 5, tag width; the table holds 1<<PCIE_TAG_BITS entries.
- ADDR_WIDTH, 32, read address width.
- TIMEOUT_CYCLES, 65535, completion timeout. Used only with the optional feature; must be less than 2^16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req_addr  in  ADDR_WIDTH  read address
- s_req_len  in  10  length in DW; 0 encodes 1024
- s_req_valid  in  1  descriptor valid
- s_req_ready  out  1  descriptor accepted
- s_tag_alloc_data  in  PCIE_TAG_BITS  tag from allocator
- s_tag_alloc_valid  in  1  tag available
- s_tag_alloc_ready  out  1  tag consumed
- m_rd_addr / m_rd_len / m_rd_tag  out  ADDR_WIDTH / 10 / PCIE_TAG_BITS  tagged request
- m_rd_valid  out  1  request valid
- m_rd_ready  in  1  formatter accepts request
- s_cpl_tag  in  PCIE_TAG_BITS  completion tag
- s_cpl_len  in  10  completion payload in DW; 0 encodes 1024
- s_cpl_valid  in  1  completion valid
- s_cpl_ready  out  1  completion accepted
- m_tag_free_data  out  PCIE_TAG_BITS  tag to release
- m_tag_free_valid  out  1  release valid
- m_tag_free_ready  in  1  allocator accepts release
- outstanding_cnt  out  PCIE_TAG_BITS+1  number of tags in flight
- err_unexp_cpl  out  1  one-cycle pulse: completion for a tag that is not outstanding
- err_overrun  out  1  one-cycle pulse: completion larger than the remaining count

Behaviour:
- Reset (rst_n low, asynchronous):
  - outstanding bitmap, remaining table, output registers, error pulses and outstanding_cnt all go to 0.
  - all valid outputs drop.
  - A reset mid-transfer discards everything in flight. The allocator is reset together with this block by system convention.

- Request path:
  - Fire condition: s_req_valid && s_tag_alloc_valid && (!m_rd_valid || m_rd_ready).
  - On fire, s_req_ready and s_tag_alloc_ready both assert in the same cycle; neither is consumed without the other.
  - The m_rd_* register loads the descriptor plus tag; m_rd_valid rises the next cycle (latency 1). Back-to-back requests sustain one per cycle.
  - Table write on fire: outstanding[tag]<=1; rem[tag]<=len, extended to 11 bits with 0 mapped to 1024.
  - m_rd_valid holds with stable data until m_rd_ready.

- Completion path:
  - s_cpl_ready = !m_tag_free_valid || m_tag_free_ready.
  - On accept, rem[tag] is read combinationally and new = rem - cpl_len (11-bit).
  - Tag not outstanding: drop the completion, pulse err_unexp_cpl the next cycle, no table change.
  - cpl_len > rem: pulse err_overrun, clear the tag and free it.
  - new == 0: clear outstanding[tag] and load the free register; m_tag_free_valid is high the next cycle.
  - Otherwise write new back to rem[tag].
  - Completions are accepted one per cycle, including back-to-back on the same tag; there is no read hazard because the table read is combinational.

- Simultaneous request and completion:
  - Both always target different tags, because an allocated tag cannot be outstanding. Both table updates occur in the same cycle.
  - outstanding_cnt = +1, -1, or net 0 accordingly.

- Boundaries:
  - outstanding_cnt reaches 1<<PCIE_TAG_BITS when all tags are in flight; requests then stall on s_tag_alloc_valid.
  - m_tag_free_ready low stalls completions only; the request path is unaffected.

Optional Feature:
- Macro: TAG_TRACKER_TIMEOUT_EN.
- With the macro defined:
  - a free-running 16-bit timestamp runs, and each tag stores its issue timestamp.
  - a scan pointer visits one tag per cycle, wrapping around the table.
  - If a tag is outstanding and (now - start) >= TIMEOUT_CYCLES (modulo 2^16), the tag is cleared and released through the free register, and err_timeout pulses with err_timeout_tag.
  - Priority: a completion wins the free register. The scan pointer holds while the free register is busy, or while an accepted completion targets the scanned tag.
- Without the macro: no timestamps, no scanner, and the err_timeout / err_timeout_tag ports are absent.

Decomposition:
- Shared package/header pcie_tag_defs holds:
  - PCIE_LEN_BITS=10 and REM_BITS=11;
  - the encoding function for len 0 = 1024;
  - the TIMEOUT timestamp width of 16.
- One sub-module, pcie_tag_rem_table: register array with combinational read, one request-write port and one completion-write port, plus the outstanding bitmap.

Test Plan:
- Post-reset: request addr=0x1000 len=16 with tag 3 -> m_rd tag=3 len=16 one cycle later; one completion of 16 DW -> free tag 3 next cycle; outstanding_cnt 1->0.
- Split completion: tag 5, len=0 (1024) -> completions of 256 DW x4 -> free only after the fourth, no errors.
- Completion for idle tag 7 -> err_unexp_cpl pulses once, no free, table unchanged.
- Tag 2 outstanding with 8 DW remaining, completion of 12 DW -> err_overrun, tag 2 freed.
- 32 requests with m_tag_free_ready=0 held during completions -> outstanding_cnt=32, s_cpl_ready low after first free, no tag lost once ready returns.
- TAG_TRACKER_TIMEOUT_EN with TIMEOUT_CYCLES=100: tag 9 issued, no completion -> err_timeout with tag 9 within 100+32 cycles, tag freed; a late completion then gives err_unexp_cpl.

Source files
------------

// File: rtl/pcie_tag_defs.sv
// Shared widths and length encoding for the PCIe read tag tracker.
// TAG_TRACKER_TIMEOUT_EN (in the top and table files) uses TS_BITS for issue timestamps.
package pcie_tag_defs;

  localparam int unsigned PCIE_LEN_BITS = 10;
  localparam int unsigned REM_BITS      = 11;
  localparam int unsigned TS_BITS       = 16;

  // A length field of 0 means 1024 DW.
  function automatic logic [REM_BITS-1:0] len_to_rem(input logic [PCIE_LEN_BITS-1:0] len);
    return (len == '0) ? REM_BITS'(1024) : REM_BITS'(len);
  endfunction

endpackage

// File: rtl/pcie_tag_rem_table.sv
// Per-tag remaining-DW table and outstanding bitmap with combinational reads.
// TAG_TRACKER_TIMEOUT_EN adds issue timestamps, a scan read port and a scan clear port.
module pcie_tag_rem_table
  import pcie_tag_defs::*;
#(
  parameter int unsigned TAG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  logic [TAG_BITS-1:0] set_tag_i,
  input  logic [REM_BITS-1:0] set_rem_i,
`ifdef TAG_TRACKER_TIMEOUT_EN
  input  logic [TS_BITS-1:0]  set_ts_i,
  input  logic                clr2_en_i,
  input  logic [TAG_BITS-1:0] clr2_tag_i,
  input  logic [TAG_BITS-1:0] scan_tag_i,
  output logic                scan_out_c,
  output logic [TS_BITS-1:0]  scan_ts_c,
`endif
  input  logic                upd_en_i,
  input  logic [TAG_BITS-1:0] upd_tag_i,
  input  logic [REM_BITS-1:0] upd_rem_i,
  input  logic                clr_en_i,
  input  logic [TAG_BITS-1:0] clr_tag_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  output logic                rd_out_c,
  output logic [REM_BITS-1:0] rd_rem_c
);

  localparam int unsigned DEPTH = 1 << TAG_BITS;

  logic [REM_BITS-1:0] rem_q [DEPTH];
  logic [REM_BITS-1:0] rem_d [DEPTH];
  logic [DEPTH-1:0]    out_q;
  logic [DEPTH-1:0]    out_d;

  // Request set and completion update never collide: a newly allocated tag is idle.
  always_comb begin
    rem_d = rem_q;
    out_d = out_q;
    if (upd_en_i) begin
      rem_d[upd_tag_i] = upd_rem_i;
    end
    if (clr_en_i) begin
      out_d[clr_tag_i] = 1'b0;
      rem_d[clr_tag_i] = '0;
    end
`ifdef TAG_TRACKER_TIMEOUT_EN
    if (clr2_en_i) begin
      out_d[clr2_tag_i] = 1'b0;
      rem_d[clr2_tag_i] = '0;
    end
`endif
    if (set_en_i) begin
      out_d[set_tag_i] = 1'b1;
      rem_d[set_tag_i] = set_rem_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '{default: '0};
      out_q <= '0;
    end else begin
      rem_q <= rem_d;
      out_q <= out_d;
    end
  end

  assign rd_out_c = out_q[rd_tag_i];
  assign rd_rem_c = rem_q[rd_tag_i];

`ifdef TAG_TRACKER_TIMEOUT_EN
  logic [TS_BITS-1:0] ts_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '{default: '0};
    end else if (set_en_i) begin
      ts_q[set_tag_i] <= set_ts_i;
    end
  end

  assign scan_out_c = out_q[scan_tag_i];
  assign scan_ts_c  = ts_q[scan_tag_i];
`endif

endmodule

// File: rtl/pcie_rd_tag_tracker.sv
// Pairs read descriptors with tags, tracks outstanding DW per tag, frees tags on completion.
// Optional TAG_TRACKER_TIMEOUT_EN releases tags whose completions never arrive.
module pcie_rd_tag_tracker
  import pcie_tag_defs::*;
#(
  parameter int unsigned PCIE_TAG_BITS  = 5,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    s_req_addr,
  input  logic [PCIE_LEN_BITS-1:0] s_req_len,
  input  logic                     s_req_valid,
  output logic                     s_req_ready,
  input  logic [PCIE_TAG_BITS-1:0] s_tag_alloc_data,
  input  logic                     s_tag_alloc_valid,
  output logic                     s_tag_alloc_ready,
  output logic [ADDR_WIDTH-1:0]    m_rd_addr,
  output logic [PCIE_LEN_BITS-1:0] m_rd_len,
  output logic [PCIE_TAG_BITS-1:0] m_rd_tag,
  output logic                     m_rd_valid,
  input  logic                     m_rd_ready,
  input  logic [PCIE_TAG_BITS-1:0] s_cpl_tag,
  input  logic [PCIE_LEN_BITS-1:0] s_cpl_len,
  input  logic                     s_cpl_valid,
  output logic                     s_cpl_ready,
  output logic [PCIE_TAG_BITS-1:0] m_tag_free_data,
  output logic                     m_tag_free_valid,
  input  logic                     m_tag_free_ready,
`ifdef TAG_TRACKER_TIMEOUT_EN
  output logic                     err_timeout,
  output logic [PCIE_TAG_BITS-1:0] err_timeout_tag,
`endif
  output logic [PCIE_TAG_BITS:0]   outstanding_cnt,
  output logic                     err_unexp_cpl,
  output logic                     err_overrun
);

  localparam int unsigned CNT_W = PCIE_TAG_BITS + 1;

  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [PCIE_LEN_BITS-1:0] rd_len_q, rd_len_d;
  logic [PCIE_TAG_BITS-1:0] rd_tag_q, rd_tag_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [PCIE_TAG_BITS-1:0] free_data_q, free_data_d;
  logic                     free_valid_q, free_valid_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     unexp_q, unexp_d;
  logic                     overrun_q, overrun_d;

  logic                     req_fire;
  logic                     free_avail;
  logic                     cpl_acc;
  logic                     cpl_hit;
  logic                     cpl_done;
  logic                     cpl_upd;
  logic [REM_BITS-1:0]      cpl_len_rem;
  logic                     tbl_out;
  logic [REM_BITS-1:0]      tbl_rem;
  logic                     tmo_fire;

  assign req_fire          = s_req_valid && s_tag_alloc_valid && (!rd_valid_q || m_rd_ready);
  assign s_req_ready       = req_fire;
  assign s_tag_alloc_ready = req_fire;

  assign free_avail  = !free_valid_q || m_tag_free_ready;
  assign s_cpl_ready = free_avail;
  assign cpl_acc     = s_cpl_valid && free_avail;
  assign cpl_len_rem = len_to_rem(s_cpl_len);
  assign cpl_hit     = cpl_acc && tbl_out;
  // Exact match and overrun both retire the tag.
  assign cpl_done    = cpl_hit && (cpl_len_rem >= tbl_rem);
  assign cpl_upd     = cpl_hit && (cpl_len_rem < tbl_rem);

`ifdef TAG_TRACKER_TIMEOUT_EN
  localparam logic [TS_BITS-1:0] TS_LIMIT = TS_BITS'(TIMEOUT_CYCLES);

  logic [TS_BITS-1:0]       ts_q, ts_d;
  logic [PCIE_TAG_BITS-1:0] scan_ptr_q, scan_ptr_d;
  logic                     tmo_q, tmo_d;
  logic [PCIE_TAG_BITS-1:0] tmo_tag_q, tmo_tag_d;
  logic                     scan_out;
  logic [TS_BITS-1:0]       scan_ts;
  logic                     scan_cpl_hit;
  logic                     scan_hold;

  assign scan_cpl_hit = cpl_acc && (s_cpl_tag == scan_ptr_q);
  // Completions own the free register; the scanner waits its turn on the same tag.
  assign scan_hold    = !free_avail || cpl_done || scan_cpl_hit;
  assign tmo_fire     = !scan_hold && scan_out && (TS_BITS'(ts_q - scan_ts) >= TS_LIMIT);

  always_comb begin
    ts_d       = ts_q + TS_BITS'(1);
    scan_ptr_d = scan_hold ? scan_ptr_q : scan_ptr_q + PCIE_TAG_BITS'(1);
    tmo_d      = tmo_fire;
    tmo_tag_d  = tmo_fire ? scan_ptr_q : tmo_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      scan_ptr_q <= '0;
      tmo_q      <= 1'b0;
      tmo_tag_q  <= '0;
    end else begin
      ts_q       <= ts_d;
      scan_ptr_q <= scan_ptr_d;
      tmo_q      <= tmo_d;
      tmo_tag_q  <= tmo_tag_d;
    end
  end

  assign err_timeout     = tmo_q;
  assign err_timeout_tag = tmo_tag_q;
`else
  logic unused_timeout;
  assign tmo_fire       = 1'b0;
  assign unused_timeout = ^(16'(TIMEOUT_CYCLES));
`endif

  pcie_tag_rem_table #(
    .TAG_BITS (PCIE_TAG_BITS)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (req_fire),
    .set_tag_i  (s_tag_alloc_data),
    .set_rem_i  (len_to_rem(s_req_len)),
`ifdef TAG_TRACKER_TIMEOUT_EN
    .set_ts_i   (ts_q),
    .clr2_en_i  (tmo_fire),
    .clr2_tag_i (scan_ptr_q),
    .scan_tag_i (scan_ptr_q),
    .scan_out_c (scan_out),
    .scan_ts_c  (scan_ts),
`endif
    .upd_en_i   (cpl_upd),
    .upd_tag_i  (s_cpl_tag),
    .upd_rem_i  (REM_BITS'(tbl_rem - cpl_len_rem)),
    .clr_en_i   (cpl_done),
    .clr_tag_i  (s_cpl_tag),
    .rd_tag_i   (s_cpl_tag),
    .rd_out_c   (tbl_out),
    .rd_rem_c   (tbl_rem)
  );

  // Next-state for request, free and status registers.
  always_comb begin
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_tag_d     = rd_tag_q;
    rd_valid_d   = rd_valid_q;
    free_data_d  = free_data_q;
    free_valid_d = free_valid_q;
    if (req_fire) begin
      rd_addr_d  = s_req_addr;
      rd_len_d   = s_req_len;
      rd_tag_d   = s_tag_alloc_data;
      rd_valid_d = 1'b1;
    end else if (m_rd_ready) begin
      rd_valid_d = 1'b0;
    end
    if (cpl_done) begin
      free_data_d  = s_cpl_tag;
      free_valid_d = 1'b1;
    end else if (tmo_fire) begin
`ifdef TAG_TRACKER_TIMEOUT_EN
      free_data_d  = scan_ptr_q;
`endif
      free_valid_d = 1'b1;
    end else if (m_tag_free_ready) begin
      free_valid_d = 1'b0;
    end
    cnt_d     = cnt_q + CNT_W'(req_fire) - CNT_W'(cpl_done || tmo_fire);
    unexp_d   = cpl_acc && !tbl_out;
    overrun_d = cpl_hit && (cpl_len_rem > tbl_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_tag_q     <= '0;
      rd_valid_q   <= 1'b0;
      free_data_q  <= '0;
      free_valid_q <= 1'b0;
      cnt_q        <= '0;
      unexp_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      rd_tag_q     <= rd_tag_d;
      rd_valid_q   <= rd_valid_d;
      free_data_q  <= free_data_d;
      free_valid_q <= free_valid_d;
      cnt_q        <= cnt_d;
      unexp_q      <= unexp_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_rd_addr        = rd_addr_q;
  assign m_rd_len         = rd_len_q;
  assign m_rd_tag         = rd_tag_q;
  assign m_rd_valid       = rd_valid_q;
  assign m_tag_free_data  = free_data_q;
  assign m_tag_free_valid = free_valid_q;
  assign outstanding_cnt  = cnt_q;
  assign err_unexp_cpl    = unexp_q;
  assign err_overrun      = overrun_q;

endmodule
